// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and data-memory waits,
// with saturating stall/flush statistics and a sticky memory-timeout flag.
module hazard_controller (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  IDRegRs_i,
  input  logic [4:0]  IDRegRt_i,
  input  logic        EXMemRead_i,
  input  logic [4:0]  EXRegRt_i,
  input  logic        Branch_i,
  input  logic        MEMMemReq_i,
  input  logic        MemAck_i,
  input  logic        clr_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IDEXBubble_o,
  output logic        IFIDFlush_o,
  output logic        PipeHold_o,
  output logic [1:0]  State_o,
  output logic [15:0] StallCycles_o,
  output logic [7:0]  FlushCount_o,
  output logic        MemTimeout_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  state_t     state, nextState;
  logic       memStall, loadUse;
  logic       pcWr, ifIdWr, bubble, flush, hold;
  logic [7:0] waitCnt;

  assign memStall = MEMMemReq_i & ~MemAck_i;
  assign loadUse  = EXMemRead_i & (EXRegRt_i != 5'd0) &
                    ((EXRegRt_i == IDRegRs_i) | (EXRegRt_i == IDRegRt_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= RUN;
    else        state <= nextState;
  end

  // LU_STALL (and the unreachable 2'b11) ignore loadUse, so one bubble per load
  always_comb begin
    nextState = RUN;
    pcWr      = 1'b1;
    ifIdWr    = 1'b1;
    bubble    = 1'b0;
    flush     = 1'b0;
    hold      = 1'b0;
    if (memStall) begin
      hold      = 1'b1;
      pcWr      = 1'b0;
      ifIdWr    = 1'b0;
      nextState = MEM_WAIT;
    end else if (loadUse && (state == RUN || state == MEM_WAIT)) begin
      pcWr      = 1'b0;
      ifIdWr    = 1'b0;
      bubble    = 1'b1;
      nextState = LU_STALL;
    end else if (Branch_i) begin
      flush     = 1'b1;
    end
  end

  assign PCWrite_o    = rst_i & pcWr;
  assign IFIDWrite_o  = rst_i & ifIdWr;
  assign IDEXBubble_o = rst_i & bubble;
  assign IFIDFlush_o  = rst_i & flush;
  assign PipeHold_o   = rst_i & hold;
  assign State_o      = state;

  // Wait counter saturates so a very long wait never re-arms from zero
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      waitCnt <= 8'd0;
    else if (state == MEM_WAIT && memStall)
      waitCnt <= (waitCnt == 8'hFF) ? waitCnt : waitCnt + 8'd1;
    else
      waitCnt <= 8'd0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      StallCycles_o <= 16'd0;
      FlushCount_o  <= 8'd0;
      MemTimeout_o  <= 1'b0;
    end else if (clr_i) begin
      StallCycles_o <= 16'd0;
      FlushCount_o  <= 8'd0;
      MemTimeout_o  <= 1'b0;
    end else begin
      if (!pcWr && StallCycles_o != 16'hFFFF) StallCycles_o <= StallCycles_o + 16'd1;
      if (flush && FlushCount_o != 8'hFF)     FlushCount_o  <= FlushCount_o + 8'd1;
      if (waitCnt == 8'hFF && memStall)       MemTimeout_o  <= 1'b1;
    end
  end

endmodule
